// File: rtl/ser_pkg.sv
// Shared types and constants for the serializer gearbox slice.
package ser_pkg;

  typedef enum logic [1:0] {
    SER_OFF   = 2'd0,
    SER_TRAIN = 2'd1,
    SER_DATA  = 2'd2
  } ser_state_e;

  localparam logic [31:0] SER_TRAIN_PAT = 32'hA5A5_A5A5;
  localparam logic [31:0] SER_IDLE_PAT  = 32'h0F0F_0F0F;

  function automatic int slices_f(input int inW, input int outW);
    return inW / outW;
  endfunction

endpackage

// File: rtl/ser_sync_fifo.sv
// Small synchronous FIFO with occupancy count; reset flushes the pointers.
module ser_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign full_o   = (r_count == CW'(DEPTH));
  assign empty_o  = (r_count == '0);
  assign w_doPush = push_i && !full_o;
  assign w_doPop  = pop_i && !empty_o;
  assign dout_o   = r_mem[r_rdPtr];
  assign count_o  = r_count;

  // Storage is not reset; emptiness is tracked purely by pointers and count.
  always_ff @(posedge clk_i) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din_i;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ser_word_gearbox.sv
// Word-to-lane gearbox: buffers core words and streams them LSB slice first
// after a training preamble, filling gaps with idle words.
module ser_word_gearbox
  import ser_pkg::*;
#(
  parameter int                IN_W        = 32,
  parameter int                OUT_W       = 4,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                TRAIN_WORDS = 8,
  parameter logic [IN_W-1:0]   TRAIN_PAT   = IN_W'(SER_TRAIN_PAT),
  parameter logic [IN_W-1:0]   IDLE_PAT    = IN_W'(SER_IDLE_PAT)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [IN_W-1:0]               data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          link_en_i,
  output logic [OUT_W-1:0]              lane_o,
  output logic                          lane_valid_o,
  output logic                          idle_o,
  output logic [1:0]                    state_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int SLICES = slices_f(IN_W, OUT_W);
  localparam int SW     = $clog2(SLICES);
  localparam int TW     = $clog2(TRAIN_WORDS + 1);

  localparam logic [1:0] ST_OFF   = SER_OFF;
  localparam logic [1:0] ST_TRAIN = SER_TRAIN;
  localparam logic [1:0] ST_DATA  = SER_DATA;

  logic [1:0]      r_state;
  logic [SW-1:0]   r_sliceCnt;
  logic [TW-1:0]   r_trainCnt;
  logic [IN_W-1:0] r_shreg;
  logic            r_laneValid;
  logic            r_idle;

  logic            w_boundary;
  logic            w_loadData;
  logic            w_push;
  logic            w_pop;
  logic            w_fifoFull;
  logic            w_fifoEmpty;
  logic [IN_W-1:0] w_fifoDout;
  logic [IN_W-1:0] w_nextWord;

  assign w_boundary = (r_sliceCnt == SW'(SLICES - 1)) &&
                      ((r_state == ST_TRAIN) || (r_state == ST_DATA));
  // A data-side load happens at every DATA boundary and at the last TRAIN boundary.
  assign w_loadData = link_en_i && w_boundary &&
                      ((r_state == ST_DATA) || (r_trainCnt == TW'(TRAIN_WORDS)));
  assign w_pop      = w_loadData && !w_fifoEmpty;
  assign w_push     = valid_i && ready_o;
  assign w_nextWord = w_fifoEmpty ? IDLE_PAT : w_fifoDout;

  assign ready_o      = !w_fifoFull;
  assign lane_o       = r_shreg[OUT_W-1:0];
  assign lane_valid_o = r_laneValid;
  assign idle_o       = r_idle;
  assign state_o      = r_state;

  ser_sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (data_i),
    .dout_o  (w_fifoDout),
    .count_o (fifo_count_o),
    .full_o  (w_fifoFull),
    .empty_o (w_fifoEmpty)
  );

  // Dropping link_en_i abandons the in-flight word; the FIFO keeps its contents.
  always_ff @(posedge clk_i) begin
    if (rst_i || !link_en_i) begin
      r_state     <= ST_OFF;
      r_sliceCnt  <= '0;
      r_trainCnt  <= '0;
      r_shreg     <= '0;
      r_laneValid <= 1'b0;
      r_idle      <= 1'b0;
    end else begin
      r_idle      <= 1'b0;
      r_laneValid <= 1'b1;
      case (r_state)
        ST_OFF: begin
          r_state    <= ST_TRAIN;
          r_shreg    <= TRAIN_PAT;
          r_sliceCnt <= '0;
          r_trainCnt <= TW'(1);
        end
        ST_TRAIN, ST_DATA: begin
          if (w_boundary) begin
            r_sliceCnt <= '0;
            if (w_loadData) begin
              r_state <= ST_DATA;
              r_shreg <= w_nextWord;
              r_idle  <= w_fifoEmpty;
            end else begin
              r_shreg    <= TRAIN_PAT;
              r_trainCnt <= r_trainCnt + TW'(1);
            end
          end else begin
            r_shreg    <= r_shreg >> OUT_W;
            r_sliceCnt <= r_sliceCnt + SW'(1);
          end
        end
        default: begin
          r_state     <= ST_OFF;
          r_sliceCnt  <= '0;
          r_trainCnt  <= '0;
          r_shreg     <= '0;
          r_laneValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_word_gearbox.sv
// Directed bench for ser_word_gearbox: training, idle fill, FIFO full
// handling, link drop/re-enable and mid-word reset.
module tb_ser_word_gearbox;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        link_en_i;
  logic [3:0]  lane_o;
  logic        lane_valid_o;
  logic        idle_o;
  logic [1:0]  state_o;
  logic [2:0]  fifo_count_o;

  int checks;
  int errors;

  logic [31:0] srcWords [8];
  int          srcIdx;
  int          srcLimit;

  localparam logic [31:0] TRAIN_WORD = 32'hA5A5_A5A5;
  localparam logic [31:0] IDLE_WORD  = 32'h0F0F_0F0F;

  ser_word_gearbox #(
    .IN_W        (32),
    .OUT_W       (4),
    .FIFO_DEPTH  (4),
    .TRAIN_WORDS (2),
    .TRAIN_PAT   (32'hA5A5_A5A5),
    .IDLE_PAT    (32'h0F0F_0F0F)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .link_en_i    (link_en_i),
    .lane_o       (lane_o),
    .lane_valid_o (lane_valid_o),
    .idle_o       (idle_o),
    .state_o      (state_o),
    .fifo_count_o (fifo_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with a valid/ready source that advances on accepted words.
  task automatic applyStimulus();
    logic accepted;
    accepted = valid_i && ready_o;
    @(posedge clk_i);
    #1;
    if (accepted) begin
      srcIdx++;
      if (srcIdx < srcLimit) data_i = srcWords[srcIdx];
      else valid_i = 1'b0;
    end
  endtask

  // Starts just before a load edge; gathers 8 lane slices and checks the word.
  task automatic collectWord(input string tag, input logic [31:0] expWord,
                             input logic [1:0] expState, input logic expIdle,
                             input int cnt1, input int cnt2);
    logic [31:0] w;
    w = '0;
    for (int s = 0; s < 8; s++) begin
      applyStimulus();
      w[s*4 +: 4] = lane_o;
      if (s == 0) begin
        checkOutput({tag, ".state"}, 32'(state_o), 32'(expState));
        checkOutput({tag, ".idle"}, 32'(idle_o), 32'(expIdle));
        checkOutput({tag, ".lvalid"}, 32'(lane_valid_o), 32'd1);
        checkOutput({tag, ".count0"}, 32'(fifo_count_o), 32'(cnt1));
        checkOutput({tag, ".ready0"}, 32'(ready_o), 32'(cnt1 < 4));
      end
      if (s == 1) begin
        checkOutput({tag, ".idle1"}, 32'(idle_o), 32'd0);
        checkOutput({tag, ".count1"}, 32'(fifo_count_o), 32'(cnt2));
      end
    end
    checkOutput({tag, ".word"}, w, expWord);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_i     = 1'b1;
    link_en_i = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    srcIdx    = 0;
    srcLimit  = 0;

    // Reset values
    applyStimulus();
    applyStimulus();
    checkOutput("rst.lane", 32'(lane_o), 32'd0);
    checkOutput("rst.lvalid", 32'(lane_valid_o), 32'd0);
    checkOutput("rst.idle", 32'(idle_o), 32'd0);
    checkOutput("rst.state", 32'(state_o), 32'd0);
    checkOutput("rst.count", 32'(fifo_count_o), 32'd0);
    checkOutput("rst.ready", 32'(ready_o), 32'd1);
    rst_i = 1'b0;
    applyStimulus();
    checkOutput("off.state", 32'(state_o), 32'd0);

    // Training with empty FIFO, then idle fill, then a pushed word
    link_en_i = 1'b1;
    collectWord("p1.train0", TRAIN_WORD, 2'd1, 1'b0, 0, 0);
    collectWord("p1.train1", TRAIN_WORD, 2'd1, 1'b0, 0, 0);
    srcWords[0] = 32'h7654_3210;
    srcIdx      = 0;
    srcLimit    = 1;
    data_i      = srcWords[0];
    valid_i     = 1'b1;
    collectWord("p1.idle0", IDLE_WORD, 2'd2, 1'b1, 1, 1);
    collectWord("p1.data0", 32'h7654_3210, 2'd2, 1'b0, 0, 0);
    collectWord("p1.idle1", IDLE_WORD, 2'd2, 1'b1, 0, 0);

    // Link off: fill the FIFO, fifth word must be held by the source
    link_en_i = 1'b0;
    applyStimulus();
    checkOutput("p2.off.state", 32'(state_o), 32'd0);
    checkOutput("p2.off.lane", 32'(lane_o), 32'd0);
    checkOutput("p2.off.lvalid", 32'(lane_valid_o), 32'd0);
    srcWords[0] = 32'h1357_9BDF;
    srcWords[1] = 32'h2468_ACE0;
    srcWords[2] = 32'hDEAD_BEEF;
    srcWords[3] = 32'hCAFE_F00D;
    srcWords[4] = 32'h0123_4567;
    srcWords[5] = 32'h89AB_CDEF;
    srcWords[6] = 32'h5A5A_3C3C;
    srcIdx      = 0;
    srcLimit    = 7;
    data_i      = srcWords[0];
    valid_i     = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("p2.fill.ready", 32'(ready_o), 32'd1);
      applyStimulus();
      checkOutput("p2.fill.count", 32'(fifo_count_o), 32'(k));
    end
    checkOutput("p2.full.ready", 32'(ready_o), 32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("p2.full.count", 32'(fifo_count_o), 32'd4);
    checkOutput("p2.full.ready2", 32'(ready_o), 32'd0);

    // Enable: words emerge in order, source refills behind each pop
    link_en_i = 1'b1;
    collectWord("p3.train0", TRAIN_WORD, 2'd1, 1'b0, 4, 4);
    collectWord("p3.train1", TRAIN_WORD, 2'd1, 1'b0, 4, 4);
    collectWord("p3.w0", 32'h1357_9BDF, 2'd2, 1'b0, 3, 4);
    collectWord("p3.w1", 32'h2468_ACE0, 2'd2, 1'b0, 3, 4);
    collectWord("p3.w2", 32'hDEAD_BEEF, 2'd2, 1'b0, 3, 4);

    // Drop the link at slice 3 of CAFE_F00D
    applyStimulus();
    checkOutput("p4.w3.slice0", 32'(lane_o), 32'hD);
    checkOutput("p4.w3.count", 32'(fifo_count_o), 32'd3);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("p4.w3.slice3", 32'(lane_o), 32'hF);
    link_en_i = 1'b0;
    applyStimulus();
    checkOutput("p4.drop.lane", 32'(lane_o), 32'd0);
    checkOutput("p4.drop.lvalid", 32'(lane_valid_o), 32'd0);
    checkOutput("p4.drop.state", 32'(state_o), 32'd0);
    checkOutput("p4.drop.count", 32'(fifo_count_o), 32'd3);

    // Re-enable: full training again, aborted word is not resent
    link_en_i = 1'b1;
    collectWord("p4.train0", TRAIN_WORD, 2'd1, 1'b0, 3, 3);
    srcWords[7] = 32'hFFFF_0000;
    srcIdx      = 7;
    srcLimit    = 8;
    data_i      = srcWords[7];
    valid_i     = 1'b1;
    collectWord("p4.train1", TRAIN_WORD, 2'd1, 1'b0, 4, 4);
    collectWord("p4.w4", 32'h0123_4567, 2'd2, 1'b0, 3, 3);

    // Reset mid-word with three words queued
    rst_i = 1'b1;
    applyStimulus();
    checkOutput("p5.rst.count", 32'(fifo_count_o), 32'd0);
    checkOutput("p5.rst.lvalid", 32'(lane_valid_o), 32'd0);
    checkOutput("p5.rst.state", 32'(state_o), 32'd0);
    checkOutput("p5.rst.lane", 32'(lane_o), 32'd0);
    checkOutput("p5.rst.ready", 32'(ready_o), 32'd1);
    rst_i     = 1'b0;
    link_en_i = 1'b0;
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
